// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and imem.
// Request: req/addr with ready. Response: rvalid with rready. At most one request is in flight.
interface fetch_ctrl_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic        imem_rvalid_i;
   logic        imem_rready_o;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ready_i,
      input  imem_rvalid_i,
      output imem_rready_o
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ready_i,
      output imem_rvalid_i,
      input  imem_rready_o
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: one outstanding imem request; pc_o updates the cycle after a consumed response; stall_i holds rready low.
// Redirects drain any in-flight response. Defining FETCH_CTRL_PERF_EN adds a saturating redirect counter.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h1C000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic [31:0]         new_pc_i,
   input  logic                branch_flag_i,
   input  logic [31:0]         branch_target_i,
   input  logic                stall_i,
   fetch_ctrl_if.master        imem,
   output logic [31:0]         pc_o,
   output logic                if_stall_o,
   output logic                if_flush_o
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0]         perf_redirect_cnt_o
`endif
);

   typedef enum logic [1:0] {
      RESET_S   = 2'd0,
      FETCH     = 2'd1,
      WAIT_RESP = 2'd2,
      DRAIN     = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] pc_q, pc_d;
   logic        redirect;
   logic [31:0] redirect_sel;
   logic [31:0] redirect_tgt;

   // RESET_S ignores redirects, which also keeps if_flush_o low during reset.
   always_comb begin
      redirect     = (state_q != RESET_S) && (flush_i || branch_flag_i);
      redirect_sel = flush_i ? new_pc_i : branch_target_i;
      redirect_tgt = {redirect_sel[31:2], 2'b00};
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q;
      case (state_q)
         RESET_S: state_d = FETCH;
         FETCH: begin
            if (redirect) fetch_pc_d = redirect_tgt;
            if (imem.imem_ready_i) state_d = redirect ? DRAIN : WAIT_RESP;
         end
         WAIT_RESP: begin
            if (redirect) begin
               fetch_pc_d = redirect_tgt;
               state_d    = imem.imem_rvalid_i ? FETCH : DRAIN;
            end else if (imem.imem_rvalid_i && !stall_i) begin
               pc_d       = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = FETCH;
            end
         end
         DRAIN: begin
            if (redirect) fetch_pc_d = redirect_tgt;
            // A response arriving with a redirect is still the one being drained.
            if (imem.imem_rvalid_i) state_d = FETCH;
         end
         default: state_d = RESET_S;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RESET_S;
         fetch_pc_q <= RESET_PC;
         pc_q       <= 32'h0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
      end
   end

   assign imem.imem_req_o    = (state_q == FETCH);
   assign imem.imem_addr_o   = fetch_pc_q;
   assign imem.imem_rready_o = ((state_q == WAIT_RESP) && !stall_i) || (state_q == DRAIN);
   assign pc_o               = pc_q;
   assign if_stall_o         = (state_q != FETCH) || stall_i;
   assign if_flush_o         = redirect || (state_q == DRAIN);

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_cnt_q, perf_cnt_d;

   always_comb begin
      perf_cnt_d = perf_cnt_q;
      if (redirect && (perf_cnt_q != 32'hFFFFFFFF)) perf_cnt_d = perf_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perf_cnt_q <= 32'h0;
      else      perf_cnt_q <= perf_cnt_d;
   end

   assign perf_redirect_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model (outstanding / drop flags, fetch PC).
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        stall_i;
   logic [31:0] pc_o;
   logic        if_stall_o;
   logic        if_flush_o;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_cnt;
   logic [31:0] m_perf;
`endif

   fetch_ctrl_if bus ();

   fetch_ctrl #(.RESET_PC(32'h1C000000)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush_i         (flush_i),
      .new_pc_i        (new_pc_i),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .stall_i         (stall_i),
      .imem            (bus.master),
      .pc_o            (pc_o),
      .if_stall_o      (if_stall_o),
      .if_flush_o      (if_flush_o)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .perf_redirect_cnt_o (perf_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Stimulus settings applied at the next falling edge.
   logic        s_rst, s_flush, s_branch, s_stall, s_ready, rv_hold;
   logic [31:0] s_new_pc, s_btgt;
   int          lat_max;

   // Memory side: one pending response after a programmable latency.
   logic        mem_has;
   int          mem_dly;
   logic        rv_now;

   // Model: a request is outstanding or not; an outstanding one is either wanted or to be dropped.
   logic        m_started, m_out, m_drop;
   logic [31:0] m_fpc, m_pco;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] acc_log[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_out     = 1'b0;
      m_drop    = 1'b0;
      m_fpc     = 32'h1C000000;
      m_pco     = 32'h0;
      mem_has   = 1'b0;
      mem_dly   = 0;
`ifdef FETCH_CTRL_PERF_EN
      m_perf    = 32'h0;
`endif
   endtask

   task automatic check_model();
      logic e_req, e_redirect;
      e_req      = m_started && !m_out;
      e_redirect = m_started && (s_flush || s_branch);
      chk("imem_req_o", {31'b0, bus.imem_req_o}, {31'b0, e_req});
      if (e_req) chk("imem_addr_o", bus.imem_addr_o, m_fpc);
      chk("imem_rready_o", {31'b0, bus.imem_rready_o}, {31'b0, m_out && (m_drop || !s_stall)});
      chk("if_stall_o", {31'b0, if_stall_o}, {31'b0, !e_req || s_stall});
      chk("if_flush_o", {31'b0, if_flush_o}, {31'b0, e_redirect || (m_out && m_drop)});
      chk("pc_o", pc_o, m_pco);
`ifdef FETCH_CTRL_PERF_EN
      chk("perf_cnt", perf_cnt, m_perf);
`endif
   endtask

   task automatic model_update();
      logic        redirect, taken, accepted;
      logic [31:0] tgt;
      redirect = m_started && (s_flush || s_branch);
      tgt      = (s_flush ? s_new_pc : s_btgt) & ~32'h3;
      taken    = 1'b0;
      accepted = 1'b0;
      if (!s_rst) begin
         model_reset();
      end else begin
`ifdef FETCH_CTRL_PERF_EN
         if (redirect && m_perf != 32'hFFFFFFFF) m_perf = m_perf + 1;
`endif
         if (!m_started) begin
            m_started = 1'b1;
         end else if (!m_out) begin
            if (s_ready) begin
               m_out    = 1'b1;
               m_drop   = redirect;
               accepted = 1'b1;
            end
            if (redirect) m_fpc = tgt;
         end else if (!m_drop) begin
            if (redirect) begin
               m_fpc = tgt;
               if (rv_now) taken = 1'b1;
               else        m_drop = 1'b1;
            end else if (rv_now && !s_stall) begin
               m_pco = m_fpc;
               m_fpc = m_fpc + 32'd4;
               taken = 1'b1;
            end
         end else begin
            if (redirect) m_fpc = tgt;
            if (rv_now) taken = 1'b1;
         end
         if (taken) begin
            m_out   = 1'b0;
            m_drop  = 1'b0;
            mem_has = 1'b0;
         end else if (accepted) begin
            mem_has = 1'b1;
            mem_dly = $urandom_range(0, lat_max);
         end else if (mem_has && mem_dly > 0) begin
            mem_dly = mem_dly - 1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      rst             = s_rst;
      flush_i         = s_flush;
      new_pc_i        = s_new_pc;
      branch_flag_i   = s_branch;
      branch_target_i = s_btgt;
      stall_i         = s_stall;
      bus.imem_ready_i = s_ready;
      if (!s_rst) model_reset();
      rv_now = mem_has && (mem_dly == 0) && !rv_hold;
      bus.imem_rvalid_i = rv_now;
      #1;
      check_model();
      if (bus.imem_req_o && s_ready) acc_log.push_back(bus.imem_addr_o);
      @(posedge clk);
      model_update();
   endtask

   task automatic chk_last_acc(input string nm, input logic [31:0] exp);
      if (acc_log.size() == 0) chk({nm, "_present"}, 32'h0, 32'h1);
      else                     chk(nm, acc_log[acc_log.size()-1], exp);
   endtask

   initial begin
      rst = 1'b0; flush_i = 1'b0; new_pc_i = '0; branch_flag_i = 1'b0;
      branch_target_i = '0; stall_i = 1'b0;
      bus.imem_ready_i = 1'b0; bus.imem_rvalid_i = 1'b0;
      s_rst = 1'b0; s_flush = 1'b0; s_branch = 1'b0; s_stall = 1'b0; s_ready = 1'b0;
      s_new_pc = '0; s_btgt = '0; rv_hold = 1'b0; lat_max = 0; rv_now = 1'b0;
      model_reset();

      // Reset values, with a flush request that must not show through.
      step();
      s_flush = 1'b1;
      step();
      #1;
      chk("rst_req", {31'b0, bus.imem_req_o}, 32'h0);
      chk("rst_rready", {31'b0, bus.imem_rready_o}, 32'h0);
      chk("rst_stall", {31'b0, if_stall_o}, 32'h1);
      chk("rst_flush", {31'b0, if_flush_o}, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      s_flush = 1'b0;

      // Sequential fetch after reset release.
      s_rst = 1'b1; s_ready = 1'b1;
      repeat (7) step();
      #1;
      chk("seq_pc_o", pc_o, 32'h1C000008);
      if (acc_log.size() < 3) chk("seq_acc_count", acc_log.size(), 32'd3);
      else begin
         chk("seq_addr0", acc_log[0], 32'h1C000000);
         chk("seq_addr1", acc_log[1], 32'h1C000004);
         chk("seq_addr2", acc_log[2], 32'h1C000008);
      end

      // Branch while waiting with no response: drain, target aligned down.
      rv_hold = 1'b1;
      step();
      s_ready = 1'b0; s_branch = 1'b1; s_btgt = 32'h1C000103;
      step();
      #1;
      chk("drain_req", {31'b0, bus.imem_req_o}, 32'h0);
      chk("drain_flush", {31'b0, if_flush_o}, 32'h1);
      s_branch = 1'b0; rv_hold = 1'b0;
      step();
      #1;
      chk("drain_pc_held", pc_o, 32'h1C000008);
      s_ready = 1'b1;
      step();
      chk_last_acc("branch_addr", 32'h1C000100);

      // Flush beats branch in the same cycle.
      s_flush = 1'b1; s_new_pc = 32'h1C008000; s_branch = 1'b1; s_btgt = 32'h1C000200;
      step();
      #1;
      chk("flush_both_flag", {31'b0, if_flush_o}, 32'h1);
      s_flush = 1'b0; s_branch = 1'b0;
      step();
      chk_last_acc("flush_addr", 32'h1C008000);
      step();
      #1;
      chk("flush_pc_o", pc_o, 32'h1C008000);

      // Backend stall holds a valid response for three cycles.
      step();
      s_stall = 1'b1;
      repeat (3) step();
      #1;
      chk("stall_rready", {31'b0, bus.imem_rready_o}, 32'h0);
      chk("stall_pc_held", pc_o, 32'h1C008000);
      chk("stall_if_stall", {31'b0, if_stall_o}, 32'h1);
      s_stall = 1'b0;
      step();
      #1;
      chk("stall_consumed", pc_o, 32'h1C008004);

      // PC wrap at the top of the address space.
      s_ready = 1'b0; s_branch = 1'b1; s_btgt = 32'hFFFFFFFE;
      step();
      s_branch = 1'b0; s_ready = 1'b1;
      step();
      step();
      step();
      chk_last_acc("wrap_addr", 32'h00000000);
      #1;
      chk("wrap_pc_o", pc_o, 32'hFFFFFFFC);

      // Reset asserted while waiting for a response.
      rv_hold = 1'b1;
      step();
      s_rst = 1'b0; s_flush = 1'b1;
      step();
      #1;
      chk("midrst_req", {31'b0, bus.imem_req_o}, 32'h0);
      chk("midrst_rready", {31'b0, bus.imem_rready_o}, 32'h0);
      chk("midrst_stall", {31'b0, if_stall_o}, 32'h1);
      chk("midrst_flush", {31'b0, if_flush_o}, 32'h0);
      chk("midrst_pc", pc_o, 32'h0);
      s_flush = 1'b0;
      step();
      s_rst = 1'b1; rv_hold = 1'b0; s_ready = 1'b1;
      step();
      step();
      chk_last_acc("restart_addr", 32'h1C000000);
      step();
      #1;
      chk("restart_pc_o", pc_o, 32'h1C000000);

      // Random traffic against the model.
      lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         s_rst    = ($urandom_range(0, 249) != 0);
         s_flush  = ($urandom_range(0, 9) == 0);
         s_branch = ($urandom_range(0, 6) == 0);
         s_stall  = ($urandom_range(0, 3) == 0);
         s_ready  = ($urandom_range(0, 1) == 0);
         s_new_pc = $urandom;
         s_btgt   = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C000000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports flush_i  input  1  pipeline flush request; and new_pc_i  input  32  flush target.
REQ-005 SHALL have ports branch_flag_i  input  1  taken branch; and branch_target_i  input  32  branch target.
REQ-006 SHALL have port stall_i  input  1  backend stall; 1 = response cannot be consumed.
REQ-007 SHALL have ports imem_req_o  output  1; imem_addr_o  output  32; and imem_ready_i  input  1, forming the request handshake.
REQ-008 SHALL have ports imem_rvalid_i  input  1 and imem_rready_o  output  1, forming the response handshake.
REQ-009 SHALL have ports pc_o  output  32  PC of consumed response; if_stall_o  output  1; and if_flush_o  output  1, all driving the IF buffer.

Function
REQ-010 SHALL implement states RESET_S, FETCH, WAIT_RESP, DRAIN, held in a registered state variable.
REQ-011 SHALL leave RESET_S for FETCH on the first clock edge after rst deasserts; RESET_S does not honour redirects.
REQ-012 SHALL drive imem_req_o=1 only in FETCH, with imem_addr_o equal to the internal fetch PC register.
REQ-013 SHALL accept a request when imem_req_o and imem_ready_i are both 1, then move FETCH->WAIT_RESP.
REQ-014 SHALL drive imem_rready_o = (WAIT_RESP and !stall_i) or DRAIN.
REQ-015 SHALL consume a response when imem_rvalid_i and imem_rready_o are both 1 in WAIT_RESP with no redirect; next cycle pc_o = accepted address, fetch PC += 4, state=FETCH.
REQ-016 SHALL drive if_stall_o = 1 whenever state is not FETCH or stall_i=1, and 0 otherwise.
REQ-017 SHALL treat redirect = flush_i or branch_flag_i, with priority flush_i > branch_flag_i > stall_i > sequential.
REQ-018 SHALL, on a redirect, load the fetch PC with the selected target with bits [1:0] forced to 0.
REQ-019 SHALL route redirects in FETCH without request acceptance to FETCH, and redirects in FETCH with imem_ready_i=1 to DRAIN.
REQ-020 SHALL route redirects in WAIT_RESP with imem_rvalid_i=0 to DRAIN, and with imem_rvalid_i=1 to FETCH, discarding that response.
REQ-021 SHALL, on a redirect in DRAIN, update the target and remain in DRAIN.
REQ-022 SHALL, in DRAIN, discard exactly one response (rvalid with rready) without updating pc_o, then go to FETCH.
REQ-023 SHALL drive if_flush_o combinationally = redirect or (state==DRAIN).
REQ-024 SHALL wrap PC increment modulo 2^32 (32'hFFFFFFFC + 4 -> 32'h0).
REQ-025 SHALL keep at most one request outstanding at any time.

Reset
REQ-026 SHALL, while rst=0, force state=RESET_S, fetch PC=RESET_PC, pc_o=32'h0, imem_req_o=0, imem_rready_o=0, if_stall_o=1, if_flush_o=0.
REQ-027 SHALL abandon any outstanding request on reset assertion mid-transaction, without draining it.

Configuration
REQ-028 SHALL, with macro FETCH_CTRL_PERF_EN defined, add output perf_redirect_cnt_o (32 bit), reset 0, +1 per redirect cycle, saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without FETCH_CTRL_PERF_EN, omit that port and counter; all other behaviour is identical.

Verification
REQ-030 SHALL cover reset release with imem_ready_i=1 and rvalid 1 cycle later -> imem_addr_o 1C000000, 1C000004, 1C000008; pc_o follows one cycle per response.
REQ-031 SHALL cover branch_flag_i=1, target 1C000103, in WAIT_RESP with rvalid=0 -> DRAIN; next rvalid discarded, pc_o unchanged; next imem_addr_o=1C000100.
REQ-032 SHALL cover flush_i and branch_flag_i in the same cycle (new_pc_i 1C008000, target 1C000200) -> fetch 1C008000; if_flush_o=1.
REQ-033 SHALL cover stall_i=1 for 3 cycles while rvalid=1 -> imem_rready_o=0, pc_o held, if_stall_o=1; consumed on first cycle with stall_i=0.
REQ-034 SHALL cover fetch PC FFFFFFFC consumed -> next imem_addr_o=00000000.
REQ-035 SHALL cover rst=0 asserted in WAIT_RESP -> all outputs at reset values immediately; after release fetch restarts at 1C000000 with no drain.
